// File: rtl/multicycle_alu.sv
// Execution-stage ALU with an iterative multiplier and divider.
//
// Single-cycle ops (logic, add/sub, compare, shift, NOP) register their result on the edge that
// samples start. MUL (shift-add) and DIV (restoring) run on operand magnitudes for WIDTH steps.
// The sign is applied on the final step.
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   freeze               : stall; holds all state and outputs
//   start, ALUControl    : operation request and 4-bit opcode
//   inp1, inp2, immx, npc: operand sources (op1 = notBUOp ? inp1 : npc, op2 = isImmediate ? immx : inp2)
//   unsigned_operation   : unsigned semantics for ADD/SUB/MUL/DIV/SLT/SGT
//   busy, done           : multi-cycle op in flight / one-cycle completion pulse
//   ALUResult, overFlow, zero, divByZero : registered result and flags
//
// Build option: define ALU_FAST_MUL_EN to use a combinational multiplier. MUL then completes
// like a single-cycle op.

module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             freeze,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [WIDTH-1:0] immx,
  input  logic [WIDTH-1:0] npc,
  input  logic             isImmediate,
  input  logic             notBUOp,
  input  logic             unsigned_operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             overFlow,
  output logic             zero,
  output logic             divByZero
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam logic [ShW-1:0] CntLast = {ShW{1'b1}};  // WIDTH-1, since WIDTH is a power of two

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpMul  = 4'h3;
  localparam logic [3:0] OpDiv  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpNand = 4'h7;
  localparam logic [3:0] OpNor  = 4'h8;
  localparam logic [3:0] OpXor  = 4'h9;
  localparam logic [3:0] OpSlt  = 4'hA;
  localparam logic [3:0] OpSgt  = 4'hB;
  localparam logic [3:0] OpSll  = 4'hC;
  localparam logic [3:0] OpSrl  = 4'hD;
  localparam logic [3:0] OpSla  = 4'hE;
  localparam logic [3:0] OpSra  = 4'hF;

  localparam logic [WIDTH-1:0] SignedMin = {1'b1, {(WIDTH-1){1'b0}}};

  // Applies the sign to a magnitude product. Returns {overflow, low WIDTH bits}.
  function automatic logic [WIDTH:0] mul_final(input logic [2*WIDTH-1:0] p, input logic neg,
                                               input logic uns);
    logic [2*WIDTH-1:0] s;
    logic               ovf;
    s = neg ? -p : p;
    if (uns) ovf = |p[2*WIDTH-1:WIDTH];
    else     ovf = !((&s[2*WIDTH-1:WIDTH-1]) || !(|s[2*WIDTH-1:WIDTH-1]));
    return {ovf, s[WIDTH-1:0]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [ShW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;        // MUL: upper product half; DIV: partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;        // MUL: multiplier / low half; DIV: dividend -> quotient
  logic [WIDTH-1:0] mcand_q, mcand_d;  // MUL: multiplicand; DIV: divisor (magnitudes)
  logic             neg_q, neg_d;
  logic             uns_q, uns_d;
  logic             divovf_q, divovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] op1, op2, mag1, mag2;
  logic             s1, s2;
  logic [ShW-1:0]   sh;

  always_comb begin
    op1  = notBUOp ? inp1 : npc;
    op2  = isImmediate ? immx : inp2;
    s1   = ~unsigned_operation & op1[WIDTH-1];
    s2   = ~unsigned_operation & op2[WIDTH-1];
    mag1 = s1 ? -op1 : op1;
    mag2 = s2 ? -op2 : op2;
    sh   = op2[ShW-1:0];
  end

  // Single-cycle datapath.
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] sla_probe;
  logic             lt, gt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  always_comb begin
    add_full  = {1'b0, op1} + {1'b0, op2};
    sub_full  = {1'b0, op1} - {1'b0, op2};
    lt        = unsigned_operation ? (op1 < op2) : ($signed(op1) < $signed(op2));
    gt        = unsigned_operation ? (op1 > op2) : ($signed(op1) > $signed(op2));
    // ~sh == WIDTH-1-sh: the low sh+1 bits of the probe are the bits that pass through the sign
    // position, and the upper bits repeat the sign. The shift is clean only when all bits agree.
    sla_probe = $signed(op1) >>> (~sh);
`ifdef ALU_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif
    sc_res = result_q;
    sc_ovf = 1'b0;
    case (ALUControl)
      OpAdd: begin
        sc_res = add_full[WIDTH-1:0];
        sc_ovf = unsigned_operation ? add_full[WIDTH]
               : (op1[WIDTH-1] == op2[WIDTH-1]) && (add_full[WIDTH-1] != op1[WIDTH-1]);
      end
      OpSub: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_ovf = unsigned_operation ? sub_full[WIDTH]
               : (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_full[WIDTH-1] != op1[WIDTH-1]);
      end
`ifdef ALU_FAST_MUL_EN
      OpMul:  {sc_ovf, sc_res} = mul_final(fast_prod, s1 ^ s2, unsigned_operation);
`endif
      OpAnd:  sc_res = op1 & op2;
      OpOr:   sc_res = op1 | op2;
      OpNand: sc_res = ~(op1 & op2);
      OpNor:  sc_res = ~(op1 | op2);
      OpXor:  sc_res = op1 ^ op2;
      OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, lt};
      OpSgt:  sc_res = {{(WIDTH-1){1'b0}}, gt};
      OpSll:  sc_res = op1 << sh;
      OpSrl:  sc_res = op1 >> sh;
      OpSla: begin
        sc_res = op1 << sh;
        sc_ovf = ~((&sla_probe) | ~(|sla_probe));
      end
      OpSra:  sc_res = $signed(op1) >>> sh;
      default: begin  // NOP keeps the previous result; MUL/DIV never complete through here
        sc_res = result_q;
        sc_ovf = 1'b0;
      end
    endcase
  end

  // One iteration of shift-add multiply and restoring divide.
  logic [WIDTH:0]   mul_sum, div_rs, div_diff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic             div_ok;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_rs   = {hi_q, lo_q[WIDTH-1]};
    // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
    div_diff = div_rs - {1'b0, mcand_q};
    div_ok   = ~div_diff[WIDTH];
    div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
    div_lo   = {lo_q[WIDTH-2:0], div_ok};
  end

  logic finish;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    uns_d    = uns_q;
    divovf_d = divovf_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    zero_d   = zero_q;
    finish   = 1'b0;
    if (!freeze) begin
      case (state_q)
        StMul: begin
          hi_d  = mul_hi;
          lo_d  = mul_lo;
          cnt_d = cnt_q + ShW'(1);
          if (cnt_q == CntLast) begin
            finish            = 1'b1;
            {ovf_d, result_d} = mul_final({mul_hi, mul_lo}, neg_q, uns_q);
            dbz_d             = 1'b0;
          end
        end
        StDiv: begin
          hi_d  = div_hi;
          lo_d  = div_lo;
          cnt_d = cnt_q + ShW'(1);
          if (cnt_q == CntLast) begin
            finish   = 1'b1;
            result_d = neg_q ? -div_lo : div_lo;
            ovf_d    = divovf_q;
            dbz_d    = 1'b0;
          end
        end
        default: begin  // StIdle and StDone both accept a new request
          state_d = StIdle;
          if (start) begin
            uns_d = unsigned_operation;
            neg_d = s1 ^ s2;
            cnt_d = '0;
            hi_d  = '0;
            case (ALUControl)
`ifndef ALU_FAST_MUL_EN
              OpMul: begin
                state_d = StMul;
                lo_d    = mag2;
                mcand_d = mag1;
              end
`endif
              OpDiv: begin
                if (op2 == '0) begin
                  finish   = 1'b1;
                  result_d = '1;
                  ovf_d    = 1'b0;
                  dbz_d    = 1'b1;
                end else begin
                  state_d  = StDiv;
                  lo_d     = mag1;
                  mcand_d  = mag2;
                  // MIN / -1: the magnitude quotient 2^(WIDTH-1) already reads as MIN.
                  divovf_d = ~unsigned_operation & (op1 == SignedMin) & (&op2);
                end
              end
              default: begin
                finish   = 1'b1;
                result_d = sc_res;
                ovf_d    = sc_ovf;
                dbz_d    = 1'b0;
              end
            endcase
          end
        end
      endcase
      if (finish) begin
        state_d = StDone;
        zero_d  = ~|result_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      uns_q    <= 1'b0;
      divovf_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      uns_q    <= uns_d;
      divovf_q <= divovf_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign done      = (state_q == StDone);
  assign ALUResult = result_q;
  assign overFlow  = ovf_q;
  assign zero      = zero_q;
  assign divByZero = dbz_q;

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised execution-unit ALU that replaces the single-cycle ALU in the Phase 3 execution stage. It takes a start strobe with operands and an `ALUControl` opcode, and performs single-cycle logic, add/sub, compare and shift ops. MUL and DIV run iteratively over `WIDTH` cycles under a start/busy/done handshake. Results, flags and a divide-by-zero indication are registered outputs consumed by the memory-stage pipeline register.

## Interface
- `WIDTH`, 32, datapath width; must be a power of two, 8 or greater.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `freeze` in 1: pipeline stall; holds all internal state and outputs.
- `start` in 1: operation request; sampled only when `busy`=0 and `freeze`=0.
- `ALUControl` in 4: opcode. 0000 NOP, 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV, 0101 AND, 0110 OR, 0111 NAND, 1000 NOR, 1001 XOR, 1010 SLT, 1011 SGT, 1100 SLL, 1101 SRL, 1110 SLA, 1111 SRA.
- `inp1`, `inp2` in WIDTH: register operands.
- `immx` in WIDTH: sign-extended immediate.
- `npc` in WIDTH: next PC, used for branch/jump target arithmetic.
- `isImmediate` in 1: op2 = `immx` when 1, else `inp2`.
- `notBUOp` in 1: op1 = `inp1` when 1, else `npc`.
- `unsigned_operation` in 1: selects unsigned semantics for ADD/SUB/MUL/DIV/SLT/SGT.
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle pulse; result and flags are valid.
- `ALUResult` out WIDTH: registered result; holds its value between completions.
- `overFlow` out 1: registered overflow flag.
- `zero` out 1: registered, equals (`ALUResult`==0).
- `divByZero` out 1: registered, set on DIV with op2=0.

## Operation
- op1 and op2 are muxed and latched on accept. Later input changes do not affect an op in flight.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accepted MUL goes to MUL. Accepted DIV goes to DIV; if op2=0 it goes straight to DONE.
  - All other opcodes compute combinationally and register the result in the same edge, then go to DONE.
  - MUL and DIV step once per unfrozen cycle for `WIDTH` steps, then go to DONE.
  - DONE asserts `done` and returns to IDLE.
- ADD/SUB: result is the low WIDTH bits.
  - Signed mode: `overFlow` is two's-complement overflow.
  - Unsigned mode: `overFlow` is carry-out for ADD and borrow for SUB.
- MUL uses a shift-add loop on magnitudes, and the sign is applied at the end in signed mode. `ALUResult` is the low WIDTH bits. `overFlow`=1 if the full 2·WIDTH product does not fit WIDTH bits (signed or unsigned per mode).
- DIV uses a restoring loop on magnitudes and truncates toward zero. `ALUResult` is the quotient.
  - op2=0: `ALUResult`=all ones, `divByZero`=1, `overFlow`=0.
  - Signed MIN/−1: `ALUResult`=MIN, `overFlow`=1.
- Logic ops are bitwise. SLT/SGT give 1 or 0, compared signed or unsigned per mode.
- Shifts use op2[log2(WIDTH)-1:0] as the amount. SLL and SLA shift left with zero fill; SLA sets `overFlow` if any bit shifted through the sign position differs from op1's sign. SRL zero-fills. SRA sign-fills.
- NOP: `ALUResult` is unchanged, and `done` still pulses.
- `overFlow` and `divByZero` are 0 for opcodes that do not define them.

## Timing
- Reset: state=IDLE; `busy`, `done`, `overFlow`, `divByZero`=0; `ALUResult`=0; `zero`=1. Reset mid-MUL/DIV aborts the op, and no `done` is produced.
- Single-cycle op: start accepted at edge N gives `done`=1 and valid outputs after edge N+1. `busy` stays 0.
- MUL/DIV: accepted at edge N. `busy`=1 after edges N+1..N+WIDTH. `done`=1 with the result after edge N+WIDTH+1, and `busy`=0 in that cycle. Divide-by-zero completes after edge N+1.
- `start` while `busy`=1 is ignored. `start` during the `done` cycle is accepted, giving back-to-back operation.
- `freeze`=1 stretches every state, including DONE. A frozen `done` stays high until unfrozen, and no step counter advances.
- Flags and `zero` update only on the edge that raises `done`.

## Configuration
- `ALU_FAST_MUL_EN` defined: MUL uses a combinational WIDTH×WIDTH multiplier. It completes like a single-cycle op (`done` after N+1, `busy` never set), and the MUL state is unused.
- Undefined: iterative shift-add MUL with WIDTH+1 latency, as above. Results and flags are identical in both builds.

## Test plan
- ADD, WIDTH=32, signed: 0x7FFFFFFF+1 → `ALUResult`=0x80000000, `overFlow`=1, `done` one cycle after start. Unsigned 0xFFFFFFFF+1 → 0, `overFlow`=1, `zero`=1.
- MUL signed: −3×7 → 0xFFFFFFEB, `overFlow`=0. `done` exactly 33 edges after start (iterative build) or 1 edge after (fast build). `busy` is high for 32 cycles.
- DIV: −7/2 → 0xFFFFFFFD. 0x80000000/0xFFFFFFFF signed → 0x80000000 with `overFlow`=1. 5/0 → 0xFFFFFFFF with `divByZero`=1 after 1 edge.
- Shifts: SRA 0x80000000 by 4 → 0xF8000000. SRL → 0x08000000. SLA 0x40000000 by 1 → 0x80000000 with `overFlow`=1. SLT signed −1<1 → 1; unsigned → 0.
- Handshake: a second start during DIV `busy` is ignored. Start in the `done` cycle is accepted. `freeze` for 5 cycles mid-MUL delays `done` by exactly 5.
- Reset asserted at step 10 of DIV → next cycle `busy`=0, `ALUResult`=0, `zero`=1, and no `done` pulse follows.
